// File: rtl/input_debouncer_pkg.sv
// Shared defaults and sizing helpers for the input conditioner.
package input_debouncer_pkg;

   // Board defaults: 5 buttons + 16 switches, sampled through the prescaler.
   localparam int DEFAULT_WIDTH    = 21;
   localparam int DEFAULT_PRESCALE = 1000;
   localparam int DEFAULT_STABLE   = 8;

   // Prescaler counter width; a prescale of 1 still needs one bit of storage.
   function automatic int prescale_width(input int prescale);
      return (prescale > 1) ? $clog2(prescale) : 1;
   endfunction

   // Filter counter width, large enough to hold 0..stable.
   function automatic int count_width(input int stable);
      return $clog2(stable + 1);
   endfunction

endpackage

// File: rtl/input_debouncer_bit.sv
// One conditioned input: 2-flop synchronizer, stability filter and edge pulses.
module input_debouncer_bit
   import input_debouncer_pkg::*;
#(
   parameter int STABLE = DEFAULT_STABLE
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   input  logic strobe,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = count_width(STABLE);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   // Two-stage synchronizer; only s2 is used downstream.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw_in;
         s2 <= s1;
      end
   end

   // Accept s2 only after it differs from level on STABLE consecutive strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (s2 == level) begin
            // Any bounce back to the current level restarts the count.
            cnt <= '0;
         end else if (strobe) begin
            if (cnt == CW'(STABLE - 1)) begin
               level <= s2;
               cnt   <= '0;
               rise  <= s2;
               fall  <= ~s2;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/input_debouncer.sv
// Synchronize, debounce and edge-detect a bank of board buttons/switches.
// A single shared prescaler paces all per-bit filters.
module input_debouncer
   import input_debouncer_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int PRESCALE = DEFAULT_PRESCALE,
   parameter int STABLE   = DEFAULT_STABLE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_in,
   input  logic [WIDTH-1:0] evt_clr,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             any_change,
   output logic [WIDTH-1:0] evt,
   output logic             strobe
);

   localparam int PW = prescale_width(PRESCALE);

   logic [PW-1:0] pre_cnt;
   logic [PW-1:0] pre_next;

   // Next prescaler count, wrapping after PRESCALE-1.
   always_comb begin
      pre_next = pre_cnt + PW'(1);
      if (pre_cnt == PW'(PRESCALE - 1)) begin
         pre_next = '0;
      end
   end

   // Prescaler; strobe is registered so it lines up with the cycle the count is PRESCALE-1.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt <= '0;
         strobe  <= 1'b0;
      end else begin
         pre_cnt <= pre_next;
         strobe  <= (pre_next == PW'(PRESCALE - 1));
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      input_debouncer_bit #(
         .STABLE (STABLE)
      ) u_bit (
         .clk    (clk),
         .reset  (reset),
         .raw_in (raw_in[i]),
         .strobe (strobe),
         .level  (level[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end

   assign any_change = |(rise | fall);

   // Sticky rise flags; a rise in the same cycle as its clear keeps the flag set.
   always_ff @(posedge clk) begin
      if (reset) begin
         evt <= '0;
      end else begin
         evt <= (evt & ~evt_clr) | rise;
      end
   end

endmodule
